// File: rtl/audio_sfifo.sv
// audio_sfifo: synchronous first-word-fall-through sample FIFO for interleaved
// multi-channel audio. A dual-port RAM feeds a registered output stage, and a
// fill counter drives the full/empty and programmable threshold flags.
module audio_sfifo #(
  parameter int BW       = 24,
  parameter int LGFLEN   = 5,
  parameter int NCH      = 2,
  parameter int AF_LEVEL = (1 << LGFLEN) - 4,
  parameter int AE_LEVEL = 4,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_wr,
  input  logic [BW-1:0]     i_data,
  input  logic              i_rd,
  output logic [BW-1:0]     o_data,
  output logic              o_valid,
  output logic [LGFLEN:0]   o_fill,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_afull,
  output logic              o_aempty,
  output logic              o_ovf,
  output logic              o_udf,
  output logic [CHW-1:0]    o_wr_ch,
  output logic [CHW-1:0]    o_rd_ch
);

  localparam int DEPTH = 1 << LGFLEN;
  localparam logic [LGFLEN:0] FILL_MAX = (LGFLEN+1)'(DEPTH);
  localparam logic [LGFLEN:0] AF_LVL   = (LGFLEN+1)'(AF_LEVEL);
  localparam logic [LGFLEN:0] AE_LVL   = (LGFLEN+1)'(AE_LEVEL);
  localparam logic [CHW-1:0]  CH_LAST  = CHW'(NCH - 1);

  logic [BW-1:0]   mem [DEPTH];

  logic [LGFLEN:0] wr_ptr_q, wr_ptr_d;
  logic [LGFLEN:0] rd_ptr_q, rd_ptr_d;
  logic [LGFLEN:0] fill_q, fill_d;
  logic [BW-1:0]   data_q, data_d;
  logic            valid_q, valid_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;
  logic [CHW-1:0]  wr_ch_q, wr_ch_d;
  logic [CHW-1:0]  rd_ch_q, rd_ch_d;

  logic            full, wr_acc, pop_acc, ram_has_data, load;

  // Channel index advance with wrap at the last interleaved channel.
  function automatic logic [CHW-1:0] next_ch(input logic [CHW-1:0] ch);
    next_ch = (ch == CH_LAST) ? '0 : ch + CHW'(1);
  endfunction

  // Handshake decode: flush blocks both ports; prefetch refills the output stage.
  always_comb begin
    full         = (fill_q == FILL_MAX);
    wr_acc       = i_wr && !full && !i_flush;
    pop_acc      = i_rd && valid_q && !i_flush;
    ram_has_data = (wr_ptr_q != rd_ptr_q);
    load         = (!valid_q || pop_acc) && ram_has_data && !i_flush;
  end

  // Next-state computation for pointers, fill level, output stage and flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    wr_ch_d  = wr_ch_q;
    rd_ch_d  = rd_ch_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
      valid_d  = 1'b0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
      wr_ch_d  = '0;
      rd_ch_d  = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + (LGFLEN+1)'(1);
        wr_ch_d  = next_ch(wr_ch_q);
      end
      if (pop_acc) begin
        rd_ch_d = next_ch(rd_ch_q);
      end
      if (load) begin
        data_d   = mem[rd_ptr_q[LGFLEN-1:0]];
        rd_ptr_d = rd_ptr_q + (LGFLEN+1)'(1);
        valid_d  = 1'b1;
      end else if (pop_acc) begin
        valid_d  = 1'b0;
      end
      if (wr_acc && !pop_acc) begin
        fill_d = fill_q + (LGFLEN+1)'(1);
      end else if (pop_acc && !wr_acc) begin
        fill_d = fill_q - (LGFLEN+1)'(1);
      end
      if (i_wr && full) begin
        ovf_d = 1'b1;
      end
      if (i_rd && !valid_q) begin
        udf_d = 1'b1;
      end
    end
  end

  // Sample storage: write port only, contents are not reset.
  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q[LGFLEN-1:0]] <= i_data;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      wr_ch_q  <= '0;
      rd_ch_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      wr_ch_q  <= wr_ch_d;
      rd_ch_q  <= rd_ch_d;
    end
  end

  // Status outputs decode from registered state only.
  always_comb begin
    o_data   = data_q;
    o_valid  = valid_q;
    o_fill   = fill_q;
    o_full   = (fill_q == FILL_MAX);
    o_empty  = (fill_q == '0);
    o_afull  = (fill_q >= AF_LVL);
    o_aempty = (fill_q <= AE_LVL);
    o_ovf    = ovf_q;
    o_udf    = udf_q;
    o_wr_ch  = wr_ch_q;
    o_rd_ch  = rd_ch_q;
  end

endmodule

// File: tb/tb_audio_sfifo.sv
// tb_audio_sfifo: directed test of audio_sfifo with a queue scoreboard and a
// small behavioural model of fill level, prefetch, sticky flags and channels.
module tb_audio_sfifo;

  localparam int BW     = 24;
  localparam int LGFLEN = 5;
  localparam int NCH    = 2;
  localparam int DEPTH  = 32;
  localparam int AFL    = 28;
  localparam int AEL    = 4;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_flush = 1'b0;
  logic          i_wr = 1'b0;
  logic [BW-1:0] i_data = '0;
  logic          i_rd = 1'b0;
  logic [BW-1:0] o_data;
  logic          o_valid;
  logic [LGFLEN:0] o_fill;
  logic          o_full, o_empty, o_afull, o_aempty, o_ovf, o_udf;
  logic [0:0]    o_wr_ch, o_rd_ch;

  audio_sfifo #(
    .BW(BW), .LGFLEN(LGFLEN), .NCH(NCH), .AF_LEVEL(AFL), .AE_LEVEL(AEL)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_wr(i_wr),
    .i_data(i_data), .i_rd(i_rd), .o_data(o_data), .o_valid(o_valid),
    .o_fill(o_fill), .o_full(o_full), .o_empty(o_empty), .o_afull(o_afull),
    .o_aempty(o_aempty), .o_ovf(o_ovf), .o_udf(o_udf), .o_wr_ch(o_wr_ch),
    .o_rd_ch(o_rd_ch)
  );

  always #5 i_clk = ~i_clk;

  int            nvec = 0;
  int            nmis = 0;
  logic [BW-1:0] sb [$];
  int            m_fill = 0;
  logic          m_valid = 1'b0;
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;
  int            m_wch = 0;
  int            m_rch = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ":fill"},   32'(o_fill),   32'(m_fill));
    check({tag, ":valid"},  32'(o_valid),  32'(m_valid));
    check({tag, ":full"},   32'(o_full),   32'(m_fill == DEPTH));
    check({tag, ":empty"},  32'(o_empty),  32'(m_fill == 0));
    check({tag, ":afull"},  32'(o_afull),  32'(m_fill >= AFL));
    check({tag, ":aempty"}, 32'(o_aempty), 32'(m_fill <= AEL));
    check({tag, ":ovf"},    32'(o_ovf),    32'(m_ovf));
    check({tag, ":udf"},    32'(o_udf),    32'(m_udf));
    check({tag, ":wr_ch"},  32'(o_wr_ch),  32'(m_wch));
    check({tag, ":rd_ch"},  32'(o_rd_ch),  32'(m_rch));
    if (m_valid) check({tag, ":head"}, 32'(o_data), 32'(sb[0]));
  endtask

  task automatic model_reset();
    sb.delete();
    m_fill  = 0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_wch   = 0;
    m_rch   = 0;
  endtask

  // One clock: compare popped data against the scoreboard before the edge,
  // advance the model across the edge, then check every output.
  task automatic step(input string tag, input logic wr, input logic [BW-1:0] d,
                      input logic rd, input logic fl);
    logic          wacc, pacc, nv;
    int            rc;
    logic [BW-1:0] exp;
    wacc = wr && (m_fill < DEPTH) && !fl;
    pacc = rd && m_valid && !fl;
    rc   = sb.size() - (m_valid ? 1 : 0);
    if (pacc) begin
      exp = sb.pop_front();
      check({tag, ":pop_data"}, 32'(o_data), 32'(exp));
      check({tag, ":pop_ch"},   32'(o_rd_ch), 32'(m_rch));
    end
    i_wr = wr; i_data = d; i_rd = rd; i_flush = fl;
    @(posedge i_clk);
    #1;
    i_wr = 1'b0; i_rd = 1'b0; i_flush = 1'b0;
    if (fl) begin
      model_reset();
    end else begin
      if (wr && m_fill == DEPTH) m_ovf = 1'b1;
      if (rd && !m_valid)        m_udf = 1'b1;
      nv = (m_valid && !pacc) || (rc > 0);
      if (wacc) begin
        sb.push_back(d);
        m_wch = (m_wch == NCH - 1) ? 0 : m_wch + 1;
      end
      if (pacc) m_rch = (m_rch == NCH - 1) ? 0 : m_rch + 1;
      m_valid = nv;
      m_fill  = sb.size();
    end
    check_all(tag);
  endtask

  initial begin
    // Reset and reset values
    #2 i_rst = 1'b1;
    #1;
    model_reset();
    check_all("reset");
    check("reset:data", 32'(o_data), 32'h0);
    @(posedge i_clk);
    #1 i_rst = 1'b0;

    // Three writes: valid two cycles after the first write, wr_ch ends at 1
    step("wr1", 1'b1, 24'h000001, 1'b0, 1'b0);
    check("wr1:not_valid_yet", 32'(o_valid), 32'h0);
    step("wr2", 1'b1, 24'h000002, 1'b0, 1'b0);
    check("wr2:data", 32'(o_data), 32'h000001);
    step("wr3", 1'b1, 24'h000003, 1'b0, 1'b0);
    check("wr3:fill", 32'(o_fill), 32'd3);
    check("wr3:wr_ch", 32'(o_wr_ch), 32'd1);

    // Fill to capacity (threshold rise checked every step), then overflow
    for (int i = 4; i <= DEPTH; i++) step("fill", 1'b1, 24'(i), 1'b0, 1'b0);
    check("full:flag", 32'(o_full), 32'h1);
    step("ovf", 1'b1, 24'hABCDEF, 1'b0, 1'b0);
    check("ovf:flag", 32'(o_ovf), 32'h1);
    check("ovf:fill", 32'(o_fill), 32'd32);

    // Drain all 32 in order; thresholds fall back, 0xABCDEF never appears
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);
    check("drain:empty", 32'(o_empty), 32'h1);

    // Underflow, then flush clears sticky flags and channel counters
    step("udf", 1'b0, '0, 1'b1, 1'b0);
    check("udf:flag", 32'(o_udf), 32'h1);
    check("udf:ovf_sticky", 32'(o_ovf), 32'h1);
    step("flush", 1'b0, '0, 1'b0, 1'b1);
    check("flush:udf", 32'(o_udf), 32'h0);
    check("flush:ovf", 32'(o_ovf), 32'h0);

    // Prime to fill 8, then 100 cycles of simultaneous write and pop
    for (int i = 0; i < 8; i++) step("prime", 1'b1, 24'(32'h100 + i), 1'b0, 1'b0);
    for (int i = 8; i < 108; i++) step("stream", 1'b1, 24'(32'h100 + i), 1'b1, 1'b0);
    check("stream:fill", 32'(o_fill), 32'd8);

    // Grow to fill 10, then assert reset between edges
    step("pre_rst", 1'b1, 24'h000200, 1'b0, 1'b0);
    step("pre_rst", 1'b1, 24'h000201, 1'b0, 1'b0);
    check("pre_rst:fill", 32'(o_fill), 32'd10);
    #3 i_rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    check("async_rst:data", 32'(o_data), 32'h0);
    @(posedge i_clk);
    #1 i_rst = 1'b0;

    // Restart after reset at channel 0
    step("restart", 1'b1, 24'h555555, 1'b0, 1'b0);
    step("restart", 1'b0, '0, 1'b0, 1'b0);
    step("restart_pop", 1'b0, '0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
